avalon_burst_register_adapter: RTL and testbench

// - Avalon-MM slave to flat register-bank bridge; next generation of the single-beat register adapter.
// - Adds byteenable, bursts with incrementing address, waitrequest, readdatavalid, and per-beat SLVERR for unmapped addresses.
// - Sits between the interconnect and a block's REGS control/status registers.
// - Drives one-hot read/write strobes at a fixed, parametrised pipeline depth.

---
 rtl/avalon_burst_register_adapter.sv | 200 ++++++++++++++++++++
 tb/tb_avalon_burst_register_adapter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_register_adapter.sv
// Avalon-MM slave bridge onto a flat register bank: bursts, byte enables,
// waitrequest, pipelined strobes and per-beat SLVERR for unmapped words.
module avalon_burst_register_adapter #(
  parameter int BUSWIDTH = 32,
  parameter int REGS     = 8,
  parameter int LATENCY  = 1,
  parameter int MAXBURST = 16,
  parameter int ADDRW    = (REGS > 1) ? $clog2(REGS) : 1,
  parameter int BCW      = $clog2(MAXBURST) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       read,
  input  logic                       write,
  input  logic [ADDRW-1:0]           address,
  input  logic [BCW-1:0]             burstcount,
  input  logic [BUSWIDTH/8-1:0]      byteenable,
  input  logic [BUSWIDTH-1:0]        writedata,
  output logic                       waitrequest,
  output logic                       readdatavalid,
  output logic [BUSWIDTH-1:0]        readdata,
  output logic                       writeresponsevalid,
  output logic [1:0]                 response,
  output logic [REGS-1:0]            reg_read_en,
  output logic [REGS-1:0]            reg_write_en,
  output logic [BUSWIDTH-1:0]        reg_wdata,
  output logic [BUSWIDTH/8-1:0]      reg_byteen,
  input  logic [REGS*BUSWIDTH-1:0]   reg_rdata
);
  localparam int BEW = BUSWIDTH / 8;

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

  typedef struct packed {
    logic                vld;
    logic                wr;
    logic [ADDRW-1:0]    addr;
    logic [BUSWIDTH-1:0] wdata;
    logic [BEW-1:0]      be;
  } beat_t;

  state_t            state_q, state_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic [BCW-1:0]    remaining_q, remaining_d;
  logic [BCW-1:0]    bc_eff;
  beat_t             iss;
  beat_t             stb;

  always_comb begin
    if (burstcount == '0)                  bc_eff = BCW'(1);
    else if (burstcount > BCW'(MAXBURST))  bc_eff = BCW'(MAXBURST);
    else                                   bc_eff = burstcount;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    waitrequest = 1'b0;
    iss         = '0;
    unique case (state_q)
      IDLE: begin
        if (write) begin
          iss.vld   = 1'b1;
          iss.wr    = 1'b1;
          iss.addr  = address;
          iss.wdata = writedata;
          iss.be    = byteenable;
          if (bc_eff > BCW'(1)) begin
            state_d     = WBURST;
            remaining_d = bc_eff - BCW'(1);
            addr_d      = address + ADDRW'(1);
          end
        end else if (read) begin
          iss.vld  = 1'b1;
          iss.addr = address;
          if (bc_eff > BCW'(1)) begin
            state_d     = RBURST;
            remaining_d = bc_eff - BCW'(1);
            addr_d      = address + ADDRW'(1);
          end
        end
      end
      RBURST: begin
        // Self-issued beats; the master is held off until the burst drains.
        waitrequest = 1'b1;
        iss.vld     = 1'b1;
        iss.addr    = addr_q;
        addr_d      = addr_q + ADDRW'(1);
        remaining_d = remaining_q - BCW'(1);
        if (remaining_q == BCW'(1)) state_d = IDLE;
      end
      WBURST: begin
        waitrequest = read & ~write;
        if (write) begin
          iss.vld     = 1'b1;
          iss.wr      = 1'b1;
          iss.addr    = addr_q;
          iss.wdata   = writedata;
          iss.be      = byteenable;
          addr_d      = addr_q + ADDRW'(1);
          remaining_d = remaining_q - BCW'(1);
          if (remaining_q == BCW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Keeps the combinational strobe path quiet while reset is held.
    if (reset) iss.vld = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  generate
    if (LATENCY == 1) begin : g_comb
      assign stb = iss;
    end else begin : g_pipe
      beat_t pipe_q [LATENCY-1];
      beat_t pipe_d [LATENCY-1];

      always_comb begin
        pipe_d[0] = iss;
        for (int i = 1; i < LATENCY-1; i++) pipe_d[i] = pipe_q[i-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LATENCY-1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign stb = pipe_q[LATENCY-2];
    end
  endgenerate

  logic                in_range;
  logic [BUSWIDTH-1:0] rd_mux;

  assign in_range = ({1'b0, stb.addr} < (ADDRW+1)'(REGS));

  always_comb begin
    reg_read_en  = '0;
    reg_write_en = '0;
    rd_mux       = '0;
    for (int i = 0; i < REGS; i++) begin
      if (stb.vld && stb.addr == ADDRW'(i)) begin
        if (stb.wr) reg_write_en[i] = 1'b1;
        else        reg_read_en[i]  = 1'b1;
        rd_mux = reg_rdata[i*BUSWIDTH +: BUSWIDTH];
      end
    end
  end

  assign reg_wdata  = (stb.vld && stb.wr) ? stb.wdata : '0;
  assign reg_byteen = (stb.vld && stb.wr) ? stb.be    : '0;

  logic                rsp_vld_q, rsp_vld_d;
  logic                rsp_wr_q,  rsp_wr_d;
  logic                rsp_err_q, rsp_err_d;
  logic [BUSWIDTH-1:0] rdata_q,   rdata_d;

  always_comb begin
    rsp_vld_d = stb.vld;
    rsp_wr_d  = stb.vld & stb.wr;
    rsp_err_d = stb.vld & ~in_range;
    rdata_d   = (stb.vld && !stb.wr) ? rd_mux : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_vld_q <= 1'b0;
      rsp_wr_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_err_q <= rsp_err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign readdatavalid      = rsp_vld_q & ~rsp_wr_q;
  assign writeresponsevalid = rsp_vld_q &  rsp_wr_q;
  assign response           = {rsp_err_q, 1'b0};
  assign readdata           = rdata_q;

endmodule

// File: tb/tb_avalon_burst_register_adapter.sv
// Scoreboard bench: drivers push expected strobes/responses per beat, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_avalon_burst_register_adapter;
  localparam int BW    = 32;
  localparam int REGS  = 6;
  localparam int LAT   = 2;
  localparam int MAXB  = 8;
  localparam int ADDRW = 3;
  localparam int BCW   = 4;
  localparam int BEW   = BW / 8;
  localparam int ASPAN = 1 << ADDRW;

  logic                 clk, reset, read, write;
  logic [ADDRW-1:0]     address;
  logic [BCW-1:0]       burstcount;
  logic [BEW-1:0]       byteenable;
  logic [BW-1:0]        writedata;
  logic                 waitrequest, readdatavalid, writeresponsevalid;
  logic [BW-1:0]        readdata;
  logic [1:0]           response;
  logic [REGS-1:0]      reg_read_en, reg_write_en;
  logic [BW-1:0]        reg_wdata;
  logic [BEW-1:0]       reg_byteen;
  logic [REGS*BW-1:0]   reg_rdata;

  avalon_burst_register_adapter #(
    .BUSWIDTH(BW), .REGS(REGS), .LATENCY(LAT), .MAXBURST(MAXB)
  ) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .burstcount(burstcount), .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata),
    .writeresponsevalid(writeresponsevalid), .response(response),
    .reg_read_en(reg_read_en), .reg_write_en(reg_write_en), .reg_wdata(reg_wdata),
    .reg_byteen(reg_byteen), .reg_rdata(reg_rdata)
  );

  typedef struct { int cyc; bit wr; int a; logic [BW-1:0] d; logic [BEW-1:0] be; } stb_t;
  typedef struct { int cyc; bit wr; logic [1:0] resp; logic [BW-1:0] d; } rsp_t;

  stb_t          sq[$];
  rsp_t          rq[$];
  logic [BW-1:0] regval [REGS];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  bit            mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int eff(input int bc);
    if (bc == 0) return 1;
    if (bc > MAXB) return MAXB;
    return bc;
  endfunction

  // Reference: a beat accepted in cycle c strobes at c+LAT-1 and responds at c+LAT.
  task automatic push_beat(input int c, input bit wr, input int a, input logic [BW-1:0] d,
                           input logic [BEW-1:0] be);
    stb_t s;
    rsp_t r;
    if (a < REGS) begin
      s.cyc = c + LAT - 1; s.wr = wr; s.a = a; s.d = d; s.be = be;
      sq.push_back(s);
    end
    r.cyc  = c + LAT;
    r.wr   = wr;
    r.resp = (a < REGS) ? 2'b00 : 2'b10;
    r.d    = (wr || a >= REGS) ? '0 : regval[a];
    rq.push_back(r);
  endtask

  stb_t            ms;
  rsp_t            mr;
  logic [REGS-1:0] mv;

  always @(negedge clk) begin
    if (mon_en) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        fail_now("strobe_missing");
        void'(sq.pop_front());
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        ms = sq.pop_front();
        mv = '0;
        mv[ms.a] = 1'b1;
        chk("reg_write_en", reg_write_en, ms.wr ? mv : '0);
        chk("reg_read_en", reg_read_en, ms.wr ? '0 : mv);
        if (ms.wr) begin
          chk("reg_wdata", reg_wdata, ms.d);
          chk("reg_byteen", reg_byteen, ms.be);
        end
      end else begin
        chk("strobe_idle", {reg_read_en, reg_write_en}, '0);
      end

      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        fail_now("response_missing");
        void'(rq.pop_front());
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        mr = rq.pop_front();
        chk("readdatavalid", readdatavalid, !mr.wr);
        chk("writeresponsevalid", writeresponsevalid, mr.wr);
        chk("response", response, mr.resp);
        if (!mr.wr) chk("readdata", readdata, mr.d);
      end else begin
        chk("response_idle", {readdatavalid, writeresponsevalid}, '0);
      end
    end
  end

  task automatic wait_accept(input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (waitrequest && w < 64) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    if (waitrequest) fail_now(name);
  endtask

  // gap_at=-2: random gaps with random read; otherwise gap_len idle cycles before beat gap_at with read held.
  task automatic wr_burst(input int a, input int bc, input logic [BW-1:0] d0, input logic [BEW-1:0] be0,
                          input int gap_at, input int gap_len, input bit rd_first);
    int n, g;
    logic [BW-1:0]  d;
    logic [BEW-1:0] be;
    n = eff(bc);
    for (int k = 0; k < n; k++) begin
      g = 0;
      if (k > 0 && gap_at == -2) g = $urandom_range(0, 2);
      else if (k > 0 && k == gap_at) g = gap_len;
      for (int j = 0; j < g; j++) begin
        write   = 1'b0;
        read    = (gap_at == -2) ? 1'($urandom_range(0, 1)) : 1'b1;
        address = ADDRW'($urandom);
        @(negedge clk);
        chk("wburst_waitrequest", waitrequest, read);
        @(posedge clk); #1;
      end
      d  = (k == 0) ? d0 : $urandom;
      be = (k == 0) ? be0 : BEW'($urandom);
      write      = 1'b1;
      read       = (k == 0) && rd_first;
      address    = (k == 0) ? ADDRW'(a) : ADDRW'($urandom);
      burstcount = (k == 0) ? BCW'(bc) : BCW'($urandom);
      writedata  = d;
      byteenable = be;
      wait_accept("write_accept_timeout");
      push_beat(cyc, 1'b1, (a + k) % ASPAN, d, be);
      @(posedge clk); #1;
    end
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic rd_burst(input int a, input int bc, input bit drain);
    int n, w;
    n = eff(bc);
    read       = 1'b1;
    write      = 1'b0;
    address    = ADDRW'(a);
    burstcount = BCW'(bc);
    wait_accept("read_accept_timeout");
    for (int k = 0; k < n; k++) push_beat(cyc + k, 1'b0, (a + k) % ASPAN, '0, '0);
    @(posedge clk); #1;
    read       = 1'b0;
    address    = ADDRW'($urandom);
    burstcount = BCW'($urandom);
    if (drain) begin
      w = 0;
      @(negedge clk);
      while (waitrequest && w < 64) begin
        w++;
        @(posedge clk); #1;
        @(negedge clk);
      end
      chk("rburst_wait_cycles", w, n - 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero();
    chk("rst_waitrequest", waitrequest, 0);
    chk("rst_readdatavalid", readdatavalid, 0);
    chk("rst_writeresponsevalid", writeresponsevalid, 0);
    chk("rst_response", response, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_strobes", {reg_read_en, reg_write_en}, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_byteen", reg_byteen, 0);
  endtask

  task automatic drain_q();
    int w;
    w = 0;
    while ((sq.size() > 0 || rq.size() > 0) && w < 40) begin
      @(posedge clk);
      w++;
    end
    #1;
  endtask

  initial begin
    int sel, a, bc;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; burstcount = '0;
    byteenable = '0; writedata = '0; reg_rdata = '0;
    for (int i = 0; i < REGS; i++) begin
      regval[i] = $urandom;
      reg_rdata[i*BW +: BW] = regval[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    wr_burst(3, 1, 32'hDEADBEEF, 4'b0011, -1, 0, 1'b0);
    rd_burst(3, 1, 1'b1);
    rd_burst(2, 4, 1'b1);
    rd_burst(5, 3, 1'b1);
    wr_burst(6, 4, $urandom, 4'hF, 2, 2, 1'b0);
    wr_burst(1, 1, 32'h12345678, 4'b1100, -1, 0, 1'b1);
    rd_burst(0, 0, 1'b1);
    rd_burst(4, 12, 1'b1);
    wr_burst(2, 0, 32'hCAFEF00D, 4'b0101, -1, 0, 1'b0);

    repeat (60) begin
      sel = $urandom_range(0, 3);
      a   = $urandom_range(0, ASPAN - 1);
      bc  = $urandom_range(0, 10);
      case (sel)
        0, 1:    wr_burst(a, bc, $urandom, BEW'($urandom), -2, 0, sel == 1);
        2:       rd_burst(a, bc, 1'b1);
        default: rd_burst(a, bc, 1'b0);
      endcase
    end

    // Reset partway through an 8-beat read burst.
    drain_q();
    chk("pre_reset_sq_empty", sq.size(), 0);
    chk("pre_reset_rq_empty", rq.size(), 0);
    mon_en     = 1'b0;
    read       = 1'b1;
    address    = '0;
    burstcount = BCW'(8);
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero();
    @(posedge clk); #1;
    reset = 1'b0;
    sq.delete();
    rq.delete();
    @(negedge clk);
    chk("post_reset_waitrequest", waitrequest, 0);
    chk("post_reset_readdatavalid", readdatavalid, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rd_burst(0, 8, 1'b1);
    wr_burst(5, 3, $urandom, 4'hF, -2, 0, 1'b0);

    drain_q();
    chk("final_strobe_queue_empty", sq.size(), 0);
    chk("final_response_queue_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
